// File: rtl/esc_quad_pwm.sv
// Four-channel ESC PWM generator: frame-synchronous speed latching, clamped pulse widths and a
// DISARMED/ARMING/RUN sequencer. Define ESC_STAGGER_EN to offset channel k's frame by k*PERIOD/4.
module esc_quad_pwm #(
  parameter int PERIOD     = 1000000,
  parameter int MIN_PULSE  = 50000,
  parameter int GAIN       = 25,
  parameter int MAX_PULSE  = 100000,
  parameter int ARM_FRAMES = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic [10:0] frnt_spd,
  input  logic [10:0] bck_spd,
  input  logic [10:0] lft_spd,
  input  logic [10:0] rght_spd,
  output logic        frnt_pwm,
  output logic        bck_pwm,
  output logic        lft_pwm,
  output logic        rght_pwm,
  output logic        frm_strt,
  output logic        armed
);

  localparam int CW = $clog2(PERIOD);
  localparam int PW = 11 + $clog2(GAIN) + 1;
  localparam int SW = ((PW > CW) ? PW : CW) + 1;
  localparam int FW = $clog2(ARM_FRAMES) + 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

`ifdef ESC_STAGGER_EN
  localparam int STEP = PERIOD / 4;
`else
  localparam int STEP = 0;
`endif

  typedef enum logic [1:0] {DISARMED, ARMING, RUN} state_t;

  state_t        state;
  state_t        ns;
  logic [CW-1:0] cnt;
  logic [FW-1:0] fc;
  logic [10:0]   spd  [4];
  logic [CW-1:0] pw   [4];
  logic [CW-1:0] lcnt [4];
  logic [3:0]    pwm;

  assign spd[0] = frnt_spd;
  assign spd[1] = bck_spd;
  assign spd[2] = lft_spd;
  assign spd[3] = rght_spd;

  assign frnt_pwm = pwm[0];
  assign bck_pwm  = pwm[1];
  assign lft_pwm  = pwm[2];
  assign rght_pwm = pwm[3];

  // Pulse width the given state implies for a speed; product and sum are wide enough to never wrap.
  function automatic logic [CW-1:0] target(state_t s, logic [10:0] speed);
    logic [PW-1:0] prod;
    logic [SW-1:0] sum;
    prod = PW'(speed) * PW'(GAIN);
    sum  = SW'(MIN_PULSE) + SW'(prod);
    case (s)
      ARMING:  target = CW'(MIN_PULSE);
      RUN:     target = (sum > SW'(MAX_PULSE)) ? CW'(MAX_PULSE) : sum[CW-1:0];
      default: target = '0;
    endcase
  endfunction

  // Per-channel frame position: cnt shifted back by the channel's start offset, modulo PERIOD.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      logic [CW:0] diff;
      diff = {1'b0, cnt} + (CW+1)'(PERIOD - k * STEP);
      if (diff >= (CW+1)'(PERIOD)) diff = diff - (CW+1)'(PERIOD);
      lcnt[k] = diff[CW-1:0];
    end
  end

  always_comb begin
    ns = state;
    if (cnt == LAST) begin
      case (state)
        DISARMED: if (arm) ns = ARMING;
        ARMING: begin
          if (!arm) ns = DISARMED;
          else if (fc == FW'(ARM_FRAMES - 1)) ns = RUN;
        end
        RUN:      if (!arm) ns = DISARMED;
        default:  ns = DISARMED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DISARMED;
      fc    <= '0;
      armed <= 1'b0;
    end else begin
      state <= ns;
      armed <= (ns == RUN);
      if (cnt == LAST) fc <= (state == ARMING) ? fc + FW'(1) : '0;
    end
  end

  // Latching on the next state makes a boundary transition govern the very frame it opens.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      frm_strt <= 1'b0;
      pwm      <= '0;
      for (int k = 0; k < 4; k++) pw[k] <= '0;
    end else begin
      cnt      <= (cnt == LAST) ? '0 : cnt + CW'(1);
      frm_strt <= (cnt == '0);
      for (int k = 0; k < 4; k++) begin
        if (lcnt[k] == LAST) pw[k] <= target(ns, spd[k]);
        pwm[k] <= (lcnt[k] < pw[k]);
      end
    end
  end

endmodule

// File: tb/tb_esc_quad_pwm.sv
// Scoreboard bench for esc_quad_pwm with a 1000-cycle frame: expected per-frame pulse widths are
// queued as stimulus is scheduled and compared against widths measured from the DUT each frame.
module tb_esc_quad_pwm;

  localparam int PERIOD     = 1000;
  localparam int MIN_PULSE  = 100;
  localparam int GAIN       = 1;
  localparam int MAX_PULSE  = 400;
  localparam int ARM_FRAMES = 2;

  logic        clk;
  logic        rst;
  logic        arm;
  logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
  logic        frnt_pwm, bck_pwm, lft_pwm, rght_pwm;
  logic        frm_strt;
  logic        armed;
  logic [3:0]  pwm_vec;

  assign pwm_vec = {rght_pwm, lft_pwm, bck_pwm, frnt_pwm};

  typedef struct packed {
    logic [3:0][11:0] w;
    logic             armed;
  } exp_t;

  exp_t exp_q[$];
  exp_t obs;
  int   n_cmp;
  int   n_err;
  int   meas_wait;
  bit   meas_shape;

  esc_quad_pwm #(
    .PERIOD(PERIOD), .MIN_PULSE(MIN_PULSE), .GAIN(GAIN),
    .MAX_PULSE(MAX_PULSE), .ARM_FRAMES(ARM_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm),
    .frnt_spd(frnt_spd), .bck_spd(bck_spd), .lft_spd(lft_spd), .rght_spd(rght_spd),
    .frnt_pwm(frnt_pwm), .bck_pwm(bck_pwm), .lft_pwm(lft_pwm), .rght_pwm(rght_pwm),
    .frm_strt(frm_strt), .armed(armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(int f, int b, int l, int r, int a);
    exp_t e;
    e.w[0]  = 12'(f);
    e.w[1]  = 12'(b);
    e.w[2]  = 12'(l);
    e.w[3]  = 12'(r);
    e.armed = a[0];
    return e;
  endfunction

  // Action codes: 0 none, 1 arm, 2 frnt_spd, 3 bck_spd, 4 lft_spd, 5 rght_spd.
  task automatic apply_action(input int code, input int val);
    case (code)
      1: arm      = val[0];
      2: frnt_spd = 11'(val);
      3: bck_spd  = 11'(val);
      4: lft_spd  = 11'(val);
      5: rght_spd = 11'(val);
      default: ;
    endcase
  endtask

  // Waits (bounded) for frm_strt, then samples one whole frame on negedges. Index i of the frame
  // is the cycle where the DUT counter holds i+1; an action fires at index act_at.
  task automatic measure_frame(input int act_at, input int act_code, input int act_val);
    int  n;
    int  w [4];
    bit  gap;
    int  fs;
    bit  found;
    n = 0;
    while (frm_strt !== 1'b1 && n < 2 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    meas_wait = n;
    found = (frm_strt === 1'b1);
    gap = 1'b0;
    fs = 0;
    for (int k = 0; k < 4; k++) w[k] = 0;
    obs.armed = armed;
    if (found) begin
      for (int i = 0; i < PERIOD; i++) begin
        for (int k = 0; k < 4; k++) begin
          if (pwm_vec[k] === 1'b1) begin
            if (w[k] != i) gap = 1'b1;
            w[k]++;
          end else if (pwm_vec[k] !== 1'b0) begin
            gap = 1'b1;
          end
        end
        if (frm_strt === 1'b1) fs++;
        if (i == act_at) apply_action(act_code, act_val);
        @(negedge clk);
      end
    end
    for (int k = 0; k < 4; k++) obs.w[k] = 12'(w[k]);
    meas_shape = found && !gap && (fs == 1);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    arm = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({pwm_vec, frm_strt, armed} !== 6'b0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got pwm=%b frm_strt=%b armed=%b, want all 0", pwm_vec, frm_strt, armed);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      measure_frame(-1, 0, 0);
      e = exp_q.pop_front();
      if (i == 0) begin
        n_cmp++;
        if (meas_wait !== 1) begin
          n_err++;
          $display("[TB] FAIL reset_first_frm_strt: got %0d cycles after release, want 1", meas_wait);
        end
      end
      n_cmp++;
      if (!meas_shape) begin
        n_err++;
        $display("[TB] FAIL reset frame %0d shape: got irregular frm_strt/pulse, want one strobe and aligned pulses", i);
      end
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("[TB] FAIL reset frame %0d: got w=%0d/%0d/%0d/%0d armed=%0b, want w=%0d/%0d/%0d/%0d armed=%0b",
                 i, obs.w[0], obs.w[1], obs.w[2], obs.w[3], obs.armed, e.w[0], e.w[1], e.w[2], e.w[3], e.armed);
      end
    end
  endtask

  task automatic test_arming();
    int   tbl [4][8] = '{'{500, 1, 1,   0,   0,   0,   0, 0},
                         '{ -1, 0, 0, 100, 100, 100, 100, 0},
                         '{ -1, 0, 0, 100, 100, 100, 100, 0},
                         '{ -1, 0, 0, 300, 100, 100, 100, 1}};
    exp_t e;
    frnt_spd = 11'd200;
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(tbl[i][3], tbl[i][4], tbl[i][5], tbl[i][6], tbl[i][7]));
    for (int i = 0; i < 4; i++) begin
      measure_frame(tbl[i][0], tbl[i][1], tbl[i][2]);
      e = exp_q.pop_front();
      n_cmp++;
      if (!meas_shape) begin
        n_err++;
        $display("[TB] FAIL arming frame %0d shape: got irregular frm_strt/pulse, want one strobe and aligned pulses", i);
      end
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("[TB] FAIL arming frame %0d: got w=%0d/%0d/%0d/%0d armed=%0b, want w=%0d/%0d/%0d/%0d armed=%0b",
                 i, obs.w[0], obs.w[1], obs.w[2], obs.w[3], obs.armed, e.w[0], e.w[1], e.w[2], e.w[3], e.armed);
      end
    end
  endtask

  task automatic test_clamp();
    int   tbl [6][8] = '{'{600, 4, 500,  300, 100, 100, 100, 1},
                         '{600, 4, 0,    300, 100, 400, 100, 1},
                         '{600, 2, 2047, 300, 100, 100, 100, 1},
                         '{600, 4, 299,  400, 100, 100, 100, 1},
                         '{600, 2, 200,  400, 100, 399, 100, 1},
                         '{600, 4, 0,    300, 100, 399, 100, 1}};
    exp_t e;
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(tbl[i][3], tbl[i][4], tbl[i][5], tbl[i][6], tbl[i][7]));
    for (int i = 0; i < 6; i++) begin
      measure_frame(tbl[i][0], tbl[i][1], tbl[i][2]);
      e = exp_q.pop_front();
      n_cmp++;
      if (!meas_shape) begin
        n_err++;
        $display("[TB] FAIL clamp frame %0d shape: got irregular frm_strt/pulse, want one strobe and aligned pulses", i);
      end
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("[TB] FAIL clamp frame %0d: got w=%0d/%0d/%0d/%0d armed=%0b, want w=%0d/%0d/%0d/%0d armed=%0b",
                 i, obs.w[0], obs.w[1], obs.w[2], obs.w[3], obs.armed, e.w[0], e.w[1], e.w[2], e.w[3], e.armed);
      end
    end
  endtask

  task automatic test_latch_timing();
    int   tbl [6][8] = '{'{600, 3, 50,  300, 100, 100, 100, 1},
                         '{ 19, 3, 250, 300, 150, 100, 100, 1},
                         '{998, 3, 0,   300, 350, 100, 100, 1},
                         '{999, 3, 200, 300, 100, 100, 100, 1},
                         '{ -1, 0, 0,   300, 100, 100, 100, 1},
                         '{ -1, 0, 0,   300, 300, 100, 100, 1}};
    exp_t e;
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(tbl[i][3], tbl[i][4], tbl[i][5], tbl[i][6], tbl[i][7]));
    for (int i = 0; i < 6; i++) begin
      measure_frame(tbl[i][0], tbl[i][1], tbl[i][2]);
      e = exp_q.pop_front();
      n_cmp++;
      if (!meas_shape) begin
        n_err++;
        $display("[TB] FAIL latch frame %0d shape: got irregular frm_strt/pulse, want one strobe and aligned pulses", i);
      end
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("[TB] FAIL latch frame %0d: got w=%0d/%0d/%0d/%0d armed=%0b, want w=%0d/%0d/%0d/%0d armed=%0b",
                 i, obs.w[0], obs.w[1], obs.w[2], obs.w[3], obs.armed, e.w[0], e.w[1], e.w[2], e.w[3], e.armed);
      end
    end
  endtask

  task automatic test_disarm();
    int   tbl [5][8] = '{'{600, 4, 200, 300, 300, 100, 100, 1},
                         '{600, 5, 200, 300, 300, 300, 100, 1},
                         '{ 49, 1, 0,   300, 300, 300, 300, 1},
                         '{ -1, 0, 0,     0,   0,   0,   0, 0},
                         '{ -1, 0, 0,     0,   0,   0,   0, 0}};
    exp_t e;
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(tbl[i][3], tbl[i][4], tbl[i][5], tbl[i][6], tbl[i][7]));
    for (int i = 0; i < 5; i++) begin
      measure_frame(tbl[i][0], tbl[i][1], tbl[i][2]);
      e = exp_q.pop_front();
      n_cmp++;
      if (!meas_shape) begin
        n_err++;
        $display("[TB] FAIL disarm frame %0d shape: got irregular frm_strt/pulse, want one strobe and aligned pulses", i);
      end
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("[TB] FAIL disarm frame %0d: got w=%0d/%0d/%0d/%0d armed=%0b, want w=%0d/%0d/%0d/%0d armed=%0b",
                 i, obs.w[0], obs.w[1], obs.w[2], obs.w[3], obs.armed, e.w[0], e.w[1], e.w[2], e.w[3], e.armed);
      end
    end
  endtask

  // Re-arm, cut a 300-cycle pulse with reset at cnt==150, then re-arm straight back to RUN.
  task automatic test_back_to_back();
    int   pre  [3][8] = '{'{500, 1, 1,   0,   0,   0,   0, 0},
                          '{ -1, 0, 0, 100, 100, 100, 100, 0},
                          '{ -1, 0, 0, 100, 100, 100, 100, 0}};
    int   post [4][5] = '{'{  0,   0,   0,   0, 0},
                          '{100, 100, 100, 100, 0},
                          '{100, 100, 100, 100, 0},
                          '{300, 300, 300, 300, 1}};
    exp_t e;
    int   n;
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(pre[i][3], pre[i][4], pre[i][5], pre[i][6], pre[i][7]));
    for (int i = 0; i < 3; i++) begin
      measure_frame(pre[i][0], pre[i][1], pre[i][2]);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e || !meas_shape) begin
        n_err++;
        $display("[TB] FAIL rearm frame %0d: got w=%0d/%0d/%0d/%0d armed=%0b shape=%0b, want w=%0d/%0d/%0d/%0d armed=%0b shape=1",
                 i, obs.w[0], obs.w[1], obs.w[2], obs.w[3], obs.armed, meas_shape, e.w[0], e.w[1], e.w[2], e.w[3], e.armed);
      end
    end
    n = 0;
    while (frm_strt !== 1'b1 && n < 2 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    repeat (149) @(negedge clk);
    n_cmp++;
    if (pwm_vec !== 4'hF || armed !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL mid_pulse_before_reset: got pwm=%b armed=%b, want pwm=1111 armed=1", pwm_vec, armed);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({pwm_vec, frm_strt, armed} !== 6'b0) begin
      n_err++;
      $display("[TB] FAIL mid_pulse_reset: got pwm=%b frm_strt=%b armed=%b, want all 0", pwm_vec, frm_strt, armed);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(post[i][0], post[i][1], post[i][2], post[i][3], post[i][4]));
    for (int i = 0; i < 4; i++) begin
      measure_frame(-1, 0, 0);
      e = exp_q.pop_front();
      if (i == 0) begin
        n_cmp++;
        if (meas_wait !== 1) begin
          n_err++;
          $display("[TB] FAIL counter_restart: got frm_strt %0d cycles after release, want 1", meas_wait);
        end
      end
      n_cmp++;
      if (obs !== e || !meas_shape) begin
        n_err++;
        $display("[TB] FAIL post_reset frame %0d: got w=%0d/%0d/%0d/%0d armed=%0b shape=%0b, want w=%0d/%0d/%0d/%0d armed=%0b shape=1",
                 i, obs.w[0], obs.w[1], obs.w[2], obs.w[3], obs.armed, meas_shape, e.w[0], e.w[1], e.w[2], e.w[3], e.armed);
      end
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    arm      = 1'b0;
    frnt_spd = '0;
    bck_spd  = '0;
    lft_spd  = '0;
    rght_spd = '0;
    test_reset();
    test_arming();
    test_clamp();
    test_latch_timing();
    test_disarm();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
